// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: WB bypass, load-use bubble, flush.
// Define ILLEGAL_TRAP_EN to add the ex_illegal port and pass illegal opcodes down as trapping slots.
module id_ex_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic            ex_is_load,
  output logic            ex_is_store,
  output logic            ex_is_branch,
  output logic            ex_is_jump
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
`ifdef ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } slot_t;

  // x0 reads as zero; a same-cycle WB write to the source register wins over the stale RF value
  function automatic logic [XLEN-1:0] bypass(input logic [4:0] rs, input logic [XLEN-1:0] rf_data,
                                             input logic we, input logic [4:0] wrd,
                                             input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] val;
    if (rs == 5'd0) begin
      val = {XLEN{1'b0}};
    end else if (we && (wrd != 5'd0) && (wrd == rs)) begin
      val = wd;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  logic [6:0]      opcode_s;
  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;
  logic [XLEN-1:0] imm_s;
  logic            legal_s, uses_rs1_s, uses_rs2_s;
  logic            is_load_s, is_store_s, is_branch_s, is_jump_s;
  logic            lu_s, hold_s;
  slot_t           bubble_s, dec_s, slot_nxt_s, slot_r;

  assign opcode_s = if_instr[6:0];
  assign rs1_s    = if_instr[19:15];
  assign rs2_s    = if_instr[24:20];
  assign rd_s     = if_instr[11:7];
  assign rf_rs1   = rs1_s;
  assign rf_rs2   = rs2_s;

  assign imm_i_s  = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_st_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b_s  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u_s  = {if_instr[31:12], 12'h000};
  assign imm_j_s  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  assign is_load_s   = (opcode_s == OPC_LOAD);
  assign is_store_s  = (opcode_s == OPC_STORE);
  assign is_branch_s = (opcode_s == OPC_BRANCH);
  assign is_jump_s   = (opcode_s == OPC_JAL) || (opcode_s == OPC_JALR);

  // Opcode legality, source-register usage and immediate format selection
  always_comb begin
    legal_s    = 1'b1;
    uses_rs1_s = 1'b1;
    uses_rs2_s = 1'b0;
    imm_s      = {XLEN{1'b0}};
    case (opcode_s)
      OPC_OP:                                                   uses_rs2_s = 1'b1;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: imm_s = imm_i_s;
      OPC_STORE:  begin imm_s = imm_st_s; uses_rs2_s = 1'b1; end
      OPC_BRANCH: begin imm_s = imm_b_s;  uses_rs2_s = 1'b1; end
      OPC_JAL:    begin imm_s = imm_j_s;  uses_rs1_s = 1'b0; end
      OPC_LUI, OPC_AUIPC: begin imm_s = imm_u_s; uses_rs1_s = 1'b0; end
      default:    legal_s = 1'b0;
    endcase
  end

  assign lu_s = slot_r.valid && slot_r.is_load && (slot_r.rd != 5'd0) &&
                ((uses_rs1_s && (slot_r.rd == rs1_s)) || (uses_rs2_s && (slot_r.rd == rs2_s)));
  assign hold_s   = slot_r.valid && !ex_ready;
  assign id_ready = flush || (!lu_s && (ex_ready || !slot_r.valid));

  // Bubble value: everything cleared, instruction reads as the canonical NOP
  always_comb begin
    bubble_s       = {$bits(slot_t){1'b0}};
    bubble_s.instr = NOP_INSTR;
  end

  // Fully decoded slot for the instruction currently presented by IF
  always_comb begin
    dec_s           = bubble_s;
    dec_s.valid     = 1'b1;
    dec_s.pc        = if_pc;
    dec_s.instr     = if_instr;
    dec_s.rs1_val   = bypass(rs1_s, rf_rd1, wb_we, wb_rd, wb_wd);
    dec_s.rs2_val   = bypass(rs2_s, rf_rd2, wb_we, wb_rd, wb_wd);
    dec_s.imm       = imm_s;
    dec_s.rs1       = rs1_s;
    dec_s.rs2       = rs2_s;
    dec_s.rd        = rd_s;
    dec_s.rd_we     = legal_s && (rd_s != 5'd0) && !is_store_s && !is_branch_s;
    dec_s.is_load   = is_load_s;
    dec_s.is_store  = is_store_s;
    dec_s.is_branch = is_branch_s;
    dec_s.is_jump   = is_jump_s;
`ifdef ILLEGAL_TRAP_EN
    dec_s.illegal   = !legal_s;
`endif
  end

  // Slot update priority: flush, EX stall, load-use bubble, new instruction, idle bubble
  always_comb begin
    slot_nxt_s = slot_r;
    if (flush) begin
      slot_nxt_s = bubble_s;
    end else if (hold_s) begin
      slot_nxt_s = slot_r;
    end else if (lu_s) begin
      slot_nxt_s = bubble_s;
    end else if (if_valid && (legal_s || TRAP_EN)) begin
      slot_nxt_s = dec_s;
    end else begin
      slot_nxt_s = bubble_s;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= bubble_s;
    end else begin
      slot_r <= slot_nxt_s;
    end
  end

  assign ex_valid     = slot_r.valid;
  assign ex_pc        = slot_r.pc;
  assign ex_instr     = slot_r.instr;
  assign ex_rs1_val   = slot_r.rs1_val;
  assign ex_rs2_val   = slot_r.rs2_val;
  assign ex_imm       = slot_r.imm;
  assign ex_rs1       = slot_r.rs1;
  assign ex_rs2       = slot_r.rs2;
  assign ex_rd        = slot_r.rd;
  assign ex_rd_we     = slot_r.rd_we;
  assign ex_is_load   = slot_r.is_load;
  assign ex_is_store  = slot_r.is_store;
  assign ex_is_branch = slot_r.is_branch;
  assign ex_is_jump   = slot_r.is_jump;
`ifdef ILLEGAL_TRAP_EN
  assign ex_illegal   = slot_r.illegal;
`endif

endmodule
